// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch constants and FSM state encoding.
package instruction_fetch_pkg;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] PC_INC     = 32'd4;
    localparam logic [1:0]  ST_RESET   = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_FAULT   = 2'd2;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and instruction-ROM initiator feeding decode, with stall,
// zero-bubble redirect and sticky misaligned-target trap.
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] inst_addr_fetch,
    output logic [31:0] instruction_dec,
    output logic [31:0] inst_addr_dec,
    output logic        valid_dec,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dec_addr_q, dec_addr_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] count_q, count_d;
    logic        run;
    logic        misaligned;

    assign run        = state_q == ST_RUN;
    assign misaligned = redirect_addr[1:0] != 2'b00;
    // The redirect target bypasses the PC so the taken path costs no bubble.
    assign imem_addr       = redirect ? redirect_addr : pc_q;
    assign imem_en         = run & (redirect | ~stall);
    assign inst_addr_fetch = pc_q;
    assign instruction_dec = valid_q ? imem_dout : NOP_INST;
    assign inst_addr_dec   = dec_addr_q;
    assign valid_dec       = valid_q;
    assign fault           = fault_q;
    assign fault_addr      = fault_addr_q;
    assign fetch_count     = count_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        dec_addr_d   = dec_addr_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        count_d      = (valid_q && !stall) ? count_q + 32'd1 : count_q;
        if (state_q == ST_RESET) begin
            state_d = ST_RUN;
        end else if (run) begin
            if (redirect && misaligned) begin
                state_d      = ST_FAULT;
                fault_d      = 1'b1;
                fault_addr_d = redirect_addr;
                valid_d      = 1'b0;
            end else if (redirect) begin
                pc_d       = redirect_addr + PC_INC;
                dec_addr_d = redirect_addr;
                valid_d    = 1'b1;
            end else if (!stall) begin
                pc_d       = pc_q + PC_INC;
                dec_addr_d = pc_q;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RESET;
            pc_q         <= RESET_ADDR;
            dec_addr_q   <= 32'd0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            dec_addr_q   <= dec_addr_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios against a 1-cycle synchronous ROM model.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_addr;
    logic        imem_en;
    logic [31:0] imem_addr, imem_dout;
    logic [31:0] inst_addr_fetch, instruction_dec, inst_addr_dec;
    logic        valid_dec, fault;
    logic [31:0] fault_addr, fetch_count;
    logic [31:0] rom [256];
    logic [31:0] prog [5];
    int total = 0;
    int bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_dout(imem_dout), .inst_addr_fetch(inst_addr_fetch),
        .instruction_dec(instruction_dec), .inst_addr_dec(inst_addr_dec),
        .valid_dec(valid_dec), .fault(fault), .fault_addr(fault_addr),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (imem_en) imem_dout <= rom[imem_addr[9:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
        tick(); tick();
        total++; if (valid_dec !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", valid_dec); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%h exp=0", fault); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%h exp=0", fetch_count); end
        total++; if (inst_addr_fetch !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", inst_addr_fetch); end
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%h exp=0", imem_en); end
        total++; if (instruction_dec !== NOP) begin bad++; $display("FAIL rst_nop got=%h exp=%h", instruction_dec, NOP); end
        total++; if (inst_addr_dec !== 32'd0 || fault_addr !== 32'd0) begin bad++; $display("FAIL rst_addrs got=%h/%h exp=0/0", inst_addr_dec, fault_addr); end
        rst = 1'b0;
        #1;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL cycle0_en got=%h exp=0", imem_en); end
        tick();
        total++; if (imem_en !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL cycle1_req got=%h/%h exp=1/0", imem_en, imem_addr); end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 5; i++) begin
            total++; if (inst_addr_fetch !== 32'(4 * i)) begin bad++; $display("FAIL run_pc%0d got=%h exp=%h", i, inst_addr_fetch, 32'(4 * i)); end
            tick();
            total++; if (instruction_dec !== prog[i] || inst_addr_dec !== 32'(4 * i) || valid_dec !== 1'b1) begin
                bad++; $display("FAIL run_dec%0d got=%h@%h v=%h exp=%h@%h v=1", i, instruction_dec, inst_addr_dec, valid_dec, prog[i], 32'(4 * i));
            end
        end
        total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL run_count got=%0d exp=4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick(); tick();
        stall = 1'b1;
        #1;
        total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL stall_en got=%h exp=0", imem_en); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (instruction_dec !== 32'h007302b3 || inst_addr_dec !== 32'd8 || imem_en !== 1'b0 || fetch_count !== 32'd2) begin
                bad++; $display("FAIL stall%0d got=%h@%h en=%h cnt=%0d exp=007302b3@8 en=0 cnt=2", i, instruction_dec, inst_addr_dec, imem_en, fetch_count);
            end
        end
        stall = 1'b0;
        #1;
        total++; if (inst_addr_fetch !== 32'd12 || imem_en !== 1'b1) begin bad++; $display("FAIL stall_resume got=%h en=%h exp=c en=1", inst_addr_fetch, imem_en); end
        tick();
        total++; if (instruction_dec !== 32'h00628233 || inst_addr_dec !== 32'd12 || fetch_count !== 32'd3) begin
            bad++; $display("FAIL stall_after got=%h@%h cnt=%0d exp=00628233@c cnt=3", instruction_dec, inst_addr_dec, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(); tick(); tick();
        redirect = 1'b1; redirect_addr = 32'h40;
        #1;
        total++; if (imem_addr !== 32'h40 || imem_en !== 1'b1) begin bad++; $display("FAIL redir_req got=%h en=%h exp=40 en=1", imem_addr, imem_en); end
        tick();
        redirect = 1'b0;
        total++; if (inst_addr_dec !== 32'h40 || inst_addr_fetch !== 32'h44 || valid_dec !== 1'b1 || instruction_dec !== 32'hC0DE0040) begin
            bad++; $display("FAIL redir_dec got=%h@%h pc=%h v=%h exp=c0de0040@40 pc=44 v=1", instruction_dec, inst_addr_dec, inst_addr_fetch, valid_dec);
        end
        tick();
        total++; if (inst_addr_dec !== 32'h44 || instruction_dec !== 32'hC0DE0044) begin bad++; $display("FAIL redir_next got=%h@%h exp=c0de0044@44", instruction_dec, inst_addr_dec); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; redirect_addr = 32'h20; stall = 1'b1;
        #1;
        total++; if (imem_en !== 1'b1 || imem_addr !== 32'h20) begin bad++; $display("FAIL rs_req got=%h en=%h exp=20 en=1", imem_addr, imem_en); end
        tick();
        redirect = 1'b0; stall = 1'b0;
        total++; if (valid_dec !== 1'b1 || inst_addr_dec !== 32'h20 || inst_addr_fetch !== 32'h24 || instruction_dec !== 32'hC0DE0020) begin
            bad++; $display("FAIL rs_dec got=%h@%h pc=%h v=%h exp=c0de0020@20 pc=24 v=1", instruction_dec, inst_addr_dec, inst_addr_fetch, valid_dec);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        total++; if (inst_addr_fetch !== 32'd0 || fault !== 1'b0 || inst_addr_dec !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap got=pc %h f=%h dec %h exp=pc 0 f=0 dec fffffffc", inst_addr_fetch, fault, inst_addr_dec);
        end
        tick();
        total++; if (inst_addr_dec !== 32'd0 || instruction_dec !== 32'h009403b3) begin bad++; $display("FAIL wrap_next got=%h@%h exp=009403b3@0", instruction_dec, inst_addr_dec); end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_addr = 32'h22;
        tick();
        total++; if (fault !== 1'b1 || fault_addr !== 32'h22 || valid_dec !== 1'b0 || imem_en !== 1'b0 || instruction_dec !== NOP) begin
            bad++; $display("FAIL fault got=f %h fa %h v %h en %h i %h exp=f 1 fa 22 v 0 en 0 i 13", fault, fault_addr, valid_dec, imem_en, instruction_dec);
        end
        redirect_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (fault !== 1'b1 || fault_addr !== 32'h22 || valid_dec !== 1'b0 || imem_en !== 1'b0) begin
                bad++; $display("FAIL fault_hold%0d got=f %h fa %h v %h en %h exp=f 1 fa 22 v 0 en 0", i, fault, fault_addr, valid_dec, imem_en);
            end
            redirect = 1'b0;
        end
        rst = 1'b1;
        tick();
        total++; if (fault !== 1'b0 || fault_addr !== 32'd0) begin bad++; $display("FAIL fault_clear got=%h/%h exp=0/0", fault, fault_addr); end
        rst = 1'b0;
        tick();
        total++; if (inst_addr_fetch !== 32'd0 || imem_en !== 1'b1) begin bad++; $display("FAIL fault_restart got=%h en=%h exp=0 en=1", inst_addr_fetch, imem_en); end
        tick();
        total++; if (valid_dec !== 1'b1 || inst_addr_dec !== 32'd0 || instruction_dec !== 32'h009403b3) begin
            bad++; $display("FAIL fault_first got=%h@%h v=%h exp=009403b3@0 v=1", instruction_dec, inst_addr_dec, valid_dec);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(); tick(); tick(); tick();
        total++; if (inst_addr_fetch !== 32'h10 || fetch_count !== 32'd3) begin bad++; $display("FAIL mid_pre got=%h cnt=%0d exp=10 cnt=3", inst_addr_fetch, fetch_count); end
        rst = 1'b1;
        tick();
        total++; if (valid_dec !== 1'b0 || fetch_count !== 32'd0 || inst_addr_fetch !== 32'd0) begin
            bad++; $display("FAIL mid_rst got=v %h cnt %0d pc %h exp=v 0 cnt 0 pc 0", valid_dec, fetch_count, inst_addr_fetch);
        end
        rst = 1'b0;
        tick();
        test_free_run();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {16'hC0DE, 16'(i * 4)};
        prog[0] = 32'h009403b3; prog[1] = 32'h00838333; prog[2] = 32'h007302b3;
        prog[3] = 32'h00628233; prog[4] = 32'h006281b3;
        for (int i = 0; i < 5; i++) rom[i] = prog[i];
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_fault();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
